// File: rtl/reg_file_8x_if.sv
// reg_file_8x_if: port bundle for the eight-entry register file.
// Master drives the write port and read requests; slave returns
// registered read data, per-register written flags and wr_err.
//   we, wsel[7:0], wdata        : write port (wsel is one-hot)
//   re_a/raddr_a, re_b/raddr_b  : read requests, ports A and B
//   rdata_x/rvalid_x            : registered read data, one-cycle valid
//   written[7:0], wr_err        : status flags
interface reg_file_8x_if #(
    parameter int WIDTH = 8
);
    logic             we;
    logic [7:0]       wsel;
    logic [WIDTH-1:0] wdata;
    logic             re_a;
    logic [2:0]       raddr_a;
    logic             re_b;
    logic [2:0]       raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic             rvalid_a;
    logic [WIDTH-1:0] rdata_b;
    logic             rvalid_b;
    logic [7:0]       written;
    logic             wr_err;

    modport master (
        output we, wsel, wdata,
        output re_a, raddr_a, re_b, raddr_b,
        input  rdata_a, rvalid_a, rdata_b, rvalid_b,
        input  written, wr_err
    );

    modport slave (
        input  we, wsel, wdata,
        input  re_a, raddr_a, re_b, raddr_b,
        output rdata_a, rvalid_a, rdata_b, rvalid_b,
        output written, wr_err
    );
endinterface

// File: rtl/reg_file_8x.sv
// reg_file_8x: 8 x WIDTH register file, one-hot write select from the
// address decoder, two registered read ports with write-to-read bypass.
// Ports: clk, rst (async, active-high), bus (reg_file_8x_if.slave).
// Optional build macro REG0_ZERO_EN: register 0 hardwired to zero,
// written[0] permanently 1.
module reg_file_8x #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_8x_if.slave bus
);

`ifdef REG0_ZERO_EN
    localparam logic [7:0] WKEEP = 8'hFE;
    localparam logic [7:0] WFORCE = 8'h01;
`else
    localparam logic [7:0] WKEEP = 8'hFF;
    localparam logic [7:0] WFORCE = 8'h00;
`endif

    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] regs_d [8];
    logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
    logic             rvalid_a_q, rvalid_a_d;
    logic             rvalid_b_q, rvalid_b_d;
    logic [7:0]       written_q, written_d;
    logic             wr_err_q, wr_err_d;

    logic             onehot;
    logic             legal;
    logic [7:0]       wmask;

    // x & (x-1) clears the lowest set bit; zero result means <= 1 bit set
    assign onehot = (bus.wsel != 8'h00) &&
                    ((bus.wsel & (bus.wsel - 8'd1)) == 8'h00);
    assign legal  = bus.we && onehot;
    // Register 0 is masked out here when it is hardwired to zero
    assign wmask  = legal ? (bus.wsel & WKEEP) : 8'h00;

    // Read path: bypass from the write port when it targets addr
    function automatic logic [WIDTH-1:0] rd(input logic [2:0] addr);
        logic [WIDTH-1:0] v;
        if (wmask[addr]) begin
            v = bus.wdata;
        end else begin
            v = regs_q[addr];
        end
`ifdef REG0_ZERO_EN
        if (addr == 3'd0) begin
            v = '0;
        end
`endif
        return v;
    endfunction

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
            if (wmask[i]) begin
                regs_d[i] = bus.wdata;
            end
        end
        written_d  = written_q | wmask;
        wr_err_d   = bus.we && !onehot;
        rvalid_a_d = bus.re_a;
        rvalid_b_d = bus.re_b;
        rdata_a_d  = bus.re_a ? rd(bus.raddr_a) : rdata_a_q;
        rdata_b_d  = bus.re_b ? rd(bus.raddr_b) : rdata_b_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            written_q  <= 8'h00;
            wr_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            written_q  <= written_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign bus.rdata_a  = rdata_a_q;
    assign bus.rvalid_a = rvalid_a_q;
    assign bus.rdata_b  = rdata_b_q;
    assign bus.rvalid_b = rvalid_b_q;
    // Constant OR keeps written[0] high even while rst is asserted
    assign bus.written  = written_q | WFORCE;
    assign bus.wr_err   = wr_err_q;

endmodule

// File: doc/reg_file_8x.md
Name: reg_file_8x

Overview:
- Eight-entry general-purpose register file that sits directly downstream of the 3-to-8 write-address decoder. It consumes the decoder's one-hot select as its per-register write enable.
- One synchronous write port and two registered read ports (A and B).
- Write-to-read bypass, so a read issued in the same cycle as a write to that address returns the new data.
- Per-register "written" flags, so software and bench can detect reads of never-written registers.

Parameters:
- WIDTH, 8, data width of each register and of the read/write data ports.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable for the current cycle.
- wsel  input  8  one-hot write select from the decoder; bit i selects register i.
- wdata  input  WIDTH  write data.
- re_a  input  1  read request on port A.
- raddr_a  input  3  read address on port A.
- re_b  input  1  read request on port B.
- raddr_b  input  3  read address on port B.
- rdata_a  output  WIDTH  registered read data, port A.
- rvalid_a  output  1  rdata_a updated this cycle.
- rdata_b  output  WIDTH  registered read data, port B.
- rvalid_b  output  1  rdata_b updated this cycle.
- written  output  8  bit i set once register i has been written since reset.
- wr_err  output  1  pulses for one cycle when we=1 and wsel is not one-hot.

Behaviour:
- Reset:
  - Asynchronous, active-high. Whenever rst=1, all eight registers, rdata_a, rdata_b, rvalid_a, rvalid_b, written and wr_err are 0.
  - Reset asserted mid-operation discards any write or read in flight.
- Write:
  - On the rising edge with we=1 and wsel one-hot, the register at position i (wsel[i]=1) takes wdata and written[i] sets.
  - written[i] stays set until reset.
- Illegal select:
  - we=1 with wsel=8'h00 or more than one bit set: no register changes, written unchanged.
  - wr_err=1 for exactly the following cycle.
  - we=0: wsel is ignored and wr_err=0.
- Read:
  - Latency 1. On the rising edge with re_a=1, rdata_a takes the register addressed by raddr_a and rvalid_a=1 for that one cycle.
  - With re_a=0, rdata_a holds its previous value and rvalid_a=0.
  - Port B is identical and fully independent.
- Bypass:
  - Applies when re_x=1 and a legal write in the same cycle targets raddr_x (wsel[raddr_x]=1, we=1).
  - rdata_x takes wdata, not the old contents.
- Simultaneous events:
  - Both ports may read the same address in the same cycle; both return identical data.
  - Read and write to different addresses in the same cycle are independent.
- No state machine beyond the storage, the flags and the one-cycle valid/error pulses. All outputs are registered.

Optional Feature:
- Macro: REG0_ZERO_EN.
- Defined:
  - Register 0 is hardwired to zero. Writes selecting register 0 are discarded (no wr_err).
  - written[0] reads as 1 permanently, including during reset.
  - Reads of address 0 return 0, including under bypass.
- Undefined: register 0 is an ordinary register, as described in Behaviour.

Test Plan:
- Reset value: assert rst asynchronously between edges -> all outputs 0 immediately. Release, read all 8 addresses on both ports -> rdata=0, written=8'h00.
- Basic write/read: write 8'hA5 with wsel=8'b0000_1000. Next cycle re_a=1, raddr_a=3 -> following cycle rdata_a=8'hA5, rvalid_a=1, written=8'h08. Then re_a=0 -> rdata_a holds 8'hA5, rvalid_a=0.
- Bypass: register 5 holds 8'h11. In the same cycle, write 8'h3C with wsel=8'b0010_0000 and read with re_b=1, raddr_b=5 -> rdata_b=8'h3C next cycle.
- Dual read: write 8'h01..8'h08 into registers 0..7. Read ports A=2 and B=2 together, then A=7 and B=0 -> 8'h03/8'h03, then 8'h08/8'h01.
- Illegal select: we=1 with wsel=8'b0000_0011 and wdata=8'hFF -> registers 0 and 1 unchanged, wr_err=1 for one cycle. Repeat with wsel=8'h00 -> same response.
- REG0_ZERO_EN build: write 8'h77 with wsel=8'b0000_0001, then read addr 0 -> rdata=0, wr_err=0, written[0]=1.
